// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths and op-code enum for the alu block
// Contents:
//   DATA_W : operand/result width (16)
//   SH_W   : shift-amount width (4)
//   op_e   : 5-bit op-code enum; codes 0x10..0x1F are undefined
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int SH_W   = 4;

  typedef enum logic [4:0] {
    OP_PASS_A = 5'h00,
    OP_PASS_B = 5'h01,
    OP_ADD    = 5'h02,
    OP_SUB    = 5'h03,
    OP_ADC    = 5'h04,
    OP_SBC    = 5'h05,
    OP_INC    = 5'h06,
    OP_DEC    = 5'h07,
    OP_NEG    = 5'h08,
    OP_LOGIC  = 5'h09,
    OP_SHL    = 5'h0A,
    OP_SHR    = 5'h0B,
    OP_SAR    = 5'h0C,
    OP_ROL    = 5'h0D,
    OP_ROR    = 5'h0E,
    OP_MUL    = 5'h0F
  } op_e;

endpackage

// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - combinational shift/rotate unit for the alu
// Ports:
//   op     in  5        op code; only SHL/SHR/SAR/ROL/ROR are acted on
//   a      in  DATA_W   value to shift
//   sh_off in  SH_W     shift/rotate amount 0..15
//   result out DATA_W   shifted/rotated value (a for other ops or sh_off=0)
//   shout  out 1        last bit shifted/rotated out (0 when sh_off=0)
module alu_shifter
  import alu_pkg::*;
(
  input  logic [4:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [SH_W-1:0]   sh_off,
  output logic [DATA_W-1:0] result,
  output logic              shout
);

  // inv = DATA_W - sh_off; used both as the complementary rotate amount
  // and as the index of the last bit leaving the top on left shifts.
  logic [SH_W:0]   inv;
  logic [SH_W-1:0] lo_idx;
  logic            hi_bit;
  logic            lo_bit;

  assign inv    = (SH_W+1)'(DATA_W) - {1'b0, sh_off};
  assign lo_idx = sh_off - SH_W'(1);
  assign hi_bit = a[inv[SH_W-1:0]];
  assign lo_bit = a[lo_idx];

  always_comb begin
    result = a;
    shout  = 1'b0;
    case (op)
      OP_SHL: begin
        result = a << sh_off;
        shout  = hi_bit;
      end
      OP_SHR: begin
        result = a >> sh_off;
        shout  = lo_bit;
      end
      OP_SAR: begin
        result = $signed(a) >>> sh_off;
        shout  = lo_bit;
      end
      OP_ROL: begin
        // a >> 16 is zero, so sh_off=0 naturally returns a
        result = (a << sh_off) | (a >> inv);
        shout  = hi_bit;
      end
      OP_ROR: begin
        result = (a >> sh_off) | (a << inv);
        shout  = lo_bit;
      end
      default: begin
        result = a;
        shout  = 1'b0;
      end
    endcase
    // hi_bit/lo_bit index garbage positions when nothing moves
    if (sh_off == '0) shout = 1'b0;
  end

endmodule

// File: rtl/alu.sv
// rtl/alu.sv - 16-bit single-cycle-latency ALU with carry/overflow flags
// Ports:
//   clk           in  1   rising-edge clock
//   rst_n         in  1   asynchronous active-low reset
//   en            in  1   operation valid
//   a, b          in  16  operands
//   i_dst         in  4   destination tag, registered to o_dst
//   sh_off        in  4   shift/rotate amount
//   truth_table   in  4   per-bit function for LOGIC, indexed by {a[i],b[i]}
//   op            in  5   op code (alu_pkg::op_e)
//   flag_carry    out 1   registered carry/borrow
//   flag_overflow out 1   registered signed overflow
//   out_en        out 1   one-cycle result strobe
//   out           out 16  registered result
//   o_dst         out 4   registered destination tag
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        i_dst,
  input  logic [SH_W-1:0]   sh_off,
  input  logic [3:0]        truth_table,
  input  logic [4:0]        op,
  output logic              flag_carry,
  output logic              flag_overflow,
  output logic              out_en,
  output logic [DATA_W-1:0] out,
  output logic [3:0]        o_dst
);

  logic [DATA_W-1:0] sh_res;
  logic              sh_out;
  logic [DATA_W-1:0] res;
  logic              res_c;
  logic              res_v;
  logic [DATA_W:0]   t;

  alu_shifter u_shifter (
    .op     (op),
    .a      (a),
    .sh_off (sh_off),
    .result (sh_res),
    .shout  (sh_out)
  );

  // Add/sub use a 17-bit intermediate; bit 16 is carry for adds and
  // borrow for subtracts (the 17-bit difference wraps when negative).
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    t     = '0;
    case (op)
      OP_PASS_A: res = a;
      OP_PASS_B: res = b;
      OP_ADD, OP_ADC: begin
        t     = {1'b0, a} + {1'b0, b}
                + {{DATA_W{1'b0}}, (op == OP_ADC) & flag_carry};
        res   = t[DATA_W-1:0];
        res_c = t[DATA_W];
        res_v = (a[DATA_W-1] == b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB, OP_SBC: begin
        t     = {1'b0, a} - {1'b0, b}
                - {{DATA_W{1'b0}}, (op == OP_SBC) & flag_carry};
        res   = t[DATA_W-1:0];
        res_c = t[DATA_W];
        res_v = (a[DATA_W-1] != b[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_INC: begin
        t     = {1'b0, a} + (DATA_W+1)'(1);
        res   = t[DATA_W-1:0];
        res_c = t[DATA_W];
        res_v = ~a[DATA_W-1] & res[DATA_W-1];
      end
      OP_DEC: begin
        t     = {1'b0, a} - (DATA_W+1)'(1);
        res   = t[DATA_W-1:0];
        res_c = t[DATA_W];
        res_v = a[DATA_W-1] & ~res[DATA_W-1];
      end
      OP_NEG: begin
        // only 0x8000 negates to itself with the sign still set
        t     = '0 - {1'b0, a};
        res   = t[DATA_W-1:0];
        res_c = t[DATA_W];
        res_v = a[DATA_W-1] & res[DATA_W-1];
      end
      OP_LOGIC: begin
        for (int i = 0; i < DATA_W; i++) res[i] = truth_table[{a[i], b[i]}];
      end
      OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR: begin
        res   = sh_res;
        res_c = sh_out;
      end
      OP_MUL: res = a * b;
      default: begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out           <= '0;
      o_dst         <= '0;
      flag_carry    <= 1'b0;
      flag_overflow <= 1'b0;
      out_en        <= 1'b0;
    end else if (en) begin
      out           <= res;
      o_dst         <= i_dst;
      flag_carry    <= res_c;
      flag_overflow <= res_v;
      out_en        <= 1'b1;
    end else begin
      out_en        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - directed self-checking bench for the alu block
module tb_alu;
  import alu_pkg::*;

  typedef struct packed {
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  sh;
    logic [3:0]  tt;
    logic [15:0] r;
    logic        c;
    logic        v;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  i_dst;
  logic [3:0]  sh_off;
  logic [3:0]  truth_table;
  logic [4:0]  op;
  logic        flag_carry;
  logic        flag_overflow;
  logic        out_en;
  logic [15:0] out;
  logic [3:0]  o_dst;

  int checks;
  int failures;

  alu dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .a             (a),
    .b             (b),
    .i_dst         (i_dst),
    .sh_off        (sh_off),
    .truth_table   (truth_table),
    .op            (op),
    .flag_carry    (flag_carry),
    .flag_overflow (flag_overflow),
    .out_en        (out_en),
    .out           (out),
    .o_dst         (o_dst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input logic [4:0] o, input logic [15:0] va, input logic [15:0] vb,
                      input logic [3:0] sh, input logic [3:0] tt, input logic [3:0] d,
                      input logic e);
    op = o; a = va; b = vb; sh_off = sh; truth_table = tt; i_dst = d; en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step(OP_ADD, 16'h0001, 16'h0001, 4'd0, 4'd0, 4'hF, 1'b1);
    #5;
    checks++;
    if ({out, o_dst, flag_carry, flag_overflow, out_en} !== 23'd0) begin
      failures++;
      $display("FAIL reset_state got=%h/%h/%b%b%b exp=0000/0/000",
               out, o_dst, flag_carry, flag_overflow, out_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
  endtask

  task automatic test_arith;
    vec_t t [20];
    t[0]  = '{OP_ADD, 16'hFFFF, 16'h0001, 4'd0, 4'd0, 16'h0000, 1'b1, 1'b0};
    t[1]  = '{OP_ADD, 16'h7FFF, 16'h0001, 4'd0, 4'd0, 16'h8000, 1'b0, 1'b1};
    t[2]  = '{OP_SUB, 16'h0000, 16'h0001, 4'd0, 4'd0, 16'hFFFF, 1'b1, 1'b0};
    t[3]  = '{OP_SUB, 16'h8000, 16'h0001, 4'd0, 4'd0, 16'h7FFF, 1'b0, 1'b1};
    t[4]  = '{OP_ADD, 16'hFFFF, 16'h0001, 4'd0, 4'd0, 16'h0000, 1'b1, 1'b0};
    t[5]  = '{OP_ADC, 16'h0001, 16'h0001, 4'd0, 4'd0, 16'h0003, 1'b0, 1'b0};
    t[6]  = '{OP_ADC, 16'hFFFF, 16'h0000, 4'd0, 4'd0, 16'hFFFF, 1'b0, 1'b0};
    t[7]  = '{OP_SUB, 16'h0000, 16'h0001, 4'd0, 4'd0, 16'hFFFF, 1'b1, 1'b0};
    t[8]  = '{OP_SBC, 16'h0005, 16'h0002, 4'd0, 4'd0, 16'h0002, 1'b0, 1'b0};
    t[9]  = '{OP_SBC, 16'h0000, 16'h0001, 4'd0, 4'd0, 16'hFFFF, 1'b1, 1'b0};
    t[10] = '{OP_SBC, 16'h0000, 16'h0000, 4'd0, 4'd0, 16'hFFFF, 1'b1, 1'b0};
    t[11] = '{OP_INC, 16'hFFFF, 16'h0000, 4'd0, 4'd0, 16'h0000, 1'b1, 1'b0};
    t[12] = '{OP_INC, 16'h7FFF, 16'h0000, 4'd0, 4'd0, 16'h8000, 1'b0, 1'b1};
    t[13] = '{OP_DEC, 16'h0000, 16'h0000, 4'd0, 4'd0, 16'hFFFF, 1'b1, 1'b0};
    t[14] = '{OP_DEC, 16'h8000, 16'h0000, 4'd0, 4'd0, 16'h7FFF, 1'b0, 1'b1};
    t[15] = '{OP_NEG, 16'h8000, 16'h0000, 4'd0, 4'd0, 16'h8000, 1'b1, 1'b1};
    t[16] = '{OP_NEG, 16'h0000, 16'h0000, 4'd0, 4'd0, 16'h0000, 1'b0, 1'b0};
    t[17] = '{OP_NEG, 16'h0001, 16'h0000, 4'd0, 4'd0, 16'hFFFF, 1'b1, 1'b0};
    t[18] = '{OP_MUL, 16'h1234, 16'h0010, 4'd0, 4'd0, 16'h2340, 1'b0, 1'b0};
    t[19] = '{OP_MUL, 16'hFFFF, 16'hFFFF, 4'd0, 4'd0, 16'h0001, 1'b0, 1'b0};
    for (int i = 0; i < 20; i++) begin
      step(t[i].op, t[i].a, t[i].b, t[i].sh, t[i].tt, 4'(i), 1'b1);
      checks++;
      if ({out, o_dst, flag_carry, flag_overflow, out_en} !==
          {t[i].r, 4'(i), t[i].c, t[i].v, 1'b1}) begin
        failures++;
        $display("FAIL arith[%0d] got=%h/%h/%b%b%b exp=%h/%h/%b%b1", i,
                 out, o_dst, flag_carry, flag_overflow, out_en,
                 t[i].r, 4'(i), t[i].c, t[i].v);
      end
    end
  endtask

  task automatic test_logic_pass;
    vec_t t [11];
    t[0]  = '{OP_NEG,    16'h8000, 16'h0000, 4'd0, 4'd0,    16'h8000, 1'b1, 1'b1};
    t[1]  = '{OP_PASS_A, 16'h1234, 16'h5678, 4'd0, 4'd0,    16'h1234, 1'b0, 1'b0};
    t[2]  = '{OP_NEG,    16'h8000, 16'h0000, 4'd0, 4'd0,    16'h8000, 1'b1, 1'b1};
    t[3]  = '{OP_PASS_B, 16'h1234, 16'hABCD, 4'd0, 4'd0,    16'hABCD, 1'b0, 1'b0};
    t[4]  = '{OP_LOGIC,  16'hF0F0, 16'hFF00, 4'd0, 4'b1000, 16'hF000, 1'b0, 1'b0};
    t[5]  = '{OP_LOGIC,  16'hF0F0, 16'hFF00, 4'd0, 4'b0110, 16'h0FF0, 1'b0, 1'b0};
    t[6]  = '{OP_LOGIC,  16'hF0F0, 16'hFF00, 4'd0, 4'b1110, 16'hFFF0, 1'b0, 1'b0};
    t[7]  = '{OP_LOGIC,  16'hF0F0, 16'hFF00, 4'd0, 4'b0001, 16'h000F, 1'b0, 1'b0};
    t[8]  = '{OP_NEG,    16'h8000, 16'h0000, 4'd0, 4'd0,    16'h8000, 1'b1, 1'b1};
    t[9]  = '{5'h15,     16'h1234, 16'h5678, 4'd3, 4'hF,    16'h0000, 1'b0, 1'b0};
    t[10] = '{5'h1F,     16'hFFFF, 16'hFFFF, 4'd1, 4'hF,    16'h0000, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      step(t[i].op, t[i].a, t[i].b, t[i].sh, t[i].tt, 4'(15 - i), 1'b1);
      checks++;
      if ({out, o_dst, flag_carry, flag_overflow, out_en} !==
          {t[i].r, 4'(15 - i), t[i].c, t[i].v, 1'b1}) begin
        failures++;
        $display("FAIL logic_pass[%0d] got=%h/%h/%b%b%b exp=%h/%h/%b%b1", i,
                 out, o_dst, flag_carry, flag_overflow, out_en,
                 t[i].r, 4'(15 - i), t[i].c, t[i].v);
      end
    end
  endtask

  task automatic test_shift;
    vec_t t [11];
    t[0]  = '{OP_ADD, 16'h7FFF, 16'h0001, 4'd0,  4'd0, 16'h8000, 1'b0, 1'b1};
    t[1]  = '{OP_SAR, 16'h8001, 16'h0000, 4'd1,  4'd0, 16'hC000, 1'b1, 1'b0};
    t[2]  = '{OP_ROL, 16'h8001, 16'h0000, 4'd4,  4'd0, 16'h0018, 1'b0, 1'b0};
    t[3]  = '{OP_SHL, 16'h8001, 16'h0000, 4'd1,  4'd0, 16'h0002, 1'b1, 1'b0};
    t[4]  = '{OP_SHR, 16'h8001, 16'h0000, 4'd1,  4'd0, 16'h4000, 1'b1, 1'b0};
    t[5]  = '{OP_ROR, 16'h8001, 16'h0000, 4'd1,  4'd0, 16'hC000, 1'b1, 1'b0};
    t[6]  = '{OP_SAR, 16'h8000, 16'h0000, 4'd15, 4'd0, 16'hFFFF, 1'b0, 1'b0};
    t[7]  = '{OP_ROR, 16'h1234, 16'h0000, 4'd4,  4'd0, 16'h4123, 1'b0, 1'b0};
    t[8]  = '{OP_SHL, 16'h00F0, 16'h0000, 4'd12, 4'd0, 16'h0000, 1'b1, 1'b0};
    t[9]  = '{OP_SAR, 16'h8001, 16'h0000, 4'd0,  4'd0, 16'h8001, 1'b0, 1'b0};
    t[10] = '{OP_ROL, 16'h1234, 16'h0000, 4'd0,  4'd0, 16'h1234, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      step(t[i].op, t[i].a, t[i].b, t[i].sh, t[i].tt, 4'(i), 1'b1);
      checks++;
      if ({out, o_dst, flag_carry, flag_overflow, out_en} !==
          {t[i].r, 4'(i), t[i].c, t[i].v, 1'b1}) begin
        failures++;
        $display("FAIL shift[%0d] got=%h/%h/%b%b%b exp=%h/%h/%b%b1", i,
                 out, o_dst, flag_carry, flag_overflow, out_en,
                 t[i].r, 4'(i), t[i].c, t[i].v);
      end
    end
  endtask

  task automatic test_hold;
    step(OP_INC, 16'h7FFF, 16'h0000, 4'd0, 4'd0, 4'hA, 1'b1);
    checks++;
    if ({out, o_dst, flag_carry, flag_overflow, out_en} !== {16'h8000, 4'hA, 3'b011}) begin
      failures++;
      $display("FAIL hold_load got=%h/%h/%b%b%b exp=8000/a/011",
               out, o_dst, flag_carry, flag_overflow, out_en);
    end
    for (int i = 0; i < 2; i++) begin
      step(OP_ADD, 16'h0000, 16'h0001, 4'd0, 4'd0, 4'h3, 1'b0);
      checks++;
      if ({out, o_dst, flag_carry, flag_overflow, out_en} !== {16'h8000, 4'hA, 3'b010}) begin
        failures++;
        $display("FAIL hold_idle[%0d] got=%h/%h/%b%b%b exp=8000/a/010", i,
                 out, o_dst, flag_carry, flag_overflow, out_en);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 3; i++) begin
      step(OP_ADD, 16'(i), 16'(i), 4'd0, 4'd0, 4'(i), 1'b1);
      checks++;
      if ({out, o_dst, out_en} !== {16'(2 * i), 4'(i), 1'b1}) begin
        failures++;
        $display("FAIL back_to_back[%0d] got=%h/%h/%b exp=%h/%h/1", i,
                 out, o_dst, out_en, 16'(2 * i), 4'(i));
      end
    end
  endtask

  task automatic test_reset_mid;
    step(OP_ADD, 16'hFFFF, 16'h0001, 4'd0, 4'd0, 4'h5, 1'b1);
    op = OP_ADD; a = 16'h0001; b = 16'h0001; i_dst = 4'h6; en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out, o_dst, flag_carry, flag_overflow, out_en} !== 23'd0) begin
      failures++;
      $display("FAIL reset_async got=%h/%h/%b%b%b exp=0000/0/000",
               out, o_dst, flag_carry, flag_overflow, out_en);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({out, o_dst, flag_carry, flag_overflow, out_en} !== 23'd0) begin
      failures++;
      $display("FAIL reset_held got=%h/%h/%b%b%b exp=0000/0/000",
               out, o_dst, flag_carry, flag_overflow, out_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({out, out_en} !== 17'd0) begin
      failures++;
      $display("FAIL reset_release got=%h/%b exp=0000/0", out, out_en);
    end
    step(OP_ADD, 16'h0002, 16'h0003, 4'd0, 4'd0, 4'h7, 1'b1);
    checks++;
    if ({out, o_dst, flag_carry, flag_overflow, out_en} !== {16'h0005, 4'h7, 3'b001}) begin
      failures++;
      $display("FAIL reset_first_op got=%h/%h/%b%b%b exp=0005/7/001",
               out, o_dst, flag_carry, flag_overflow, out_en);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    en = 1'b0;
    a = '0;
    b = '0;
    i_dst = '0;
    sh_off = '0;
    truth_table = '0;
    op = '0;
    test_reset();
    test_arith();
    test_logic_pass();
    test_shift();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 en  input  1  operation valid; sampled each rising clk.
REQ-005 a  input  16  operand A.
REQ-006 b  input  16  operand B.
REQ-007 i_dst  input  4  destination register tag, passed through to o_dst.
REQ-008 sh_off  input  4  shift/rotate amount, 0..15.
REQ-009 truth_table  input  4  per-bit logic function for op LOGIC.
REQ-010 op  input  5  operation code, see REQ-015.
REQ-011 flag_carry  output  1  registered carry/borrow flag.
REQ-012 flag_overflow  output  1  registered signed-overflow flag.
REQ-013 out_en  output  1  result valid strobe, high one cycle per accepted op.
REQ-014 out / o_dst  output  16 / 4  registered result / registered destination tag.

Function
REQ-015 Op codes: 00 PASS_A, 01 PASS_B, 02 ADD, 03 SUB (a-b), 04 ADC (a+b+flag_carry), 05 SBC (a-b-flag_carry), 06 INC a, 07 DEC a, 08 NEG a, 09 LOGIC, 0A SHL, 0B SHR (logical), 0C SAR, 0D ROL, 0E ROR, 0F MUL (low 16 bits of a*b).
REQ-016 Latency 1: on a rising clk with en=1, out<=result, o_dst<=i_dst, flags<=computed flags, out_en<=1.
REQ-017 On a rising clk with en=0: out_en<=0; out, o_dst and both flags hold.
REQ-018 Back-to-back en=1 cycles SHALL each produce a result; no throughput stall.
REQ-019 All arithmetic is modulo 2^16.
REQ-020 Carry flag for ADD/ADC/INC: carry out of bit 15. For SUB/SBC/DEC/NEG: borrow (1 when the unsigned result is below 0).
REQ-021 Overflow flag for all add/sub-class ops: two's-complement signed overflow. NEG 0x8000 SHALL set overflow.
REQ-022 ADC/SBC SHALL use the registered flag_carry value present before the clock edge.
REQ-023 LOGIC: out[i] = truth_table[{a[i],b[i]}] for every bit i (a[i] is the index MSB).
REQ-024 Shift/rotate ops operate on a by sh_off. SAR replicates a[15]. Carry = last bit shifted/rotated out. sh_off=0 gives out=a and carry=0.
REQ-025 PASS_A, PASS_B, LOGIC, MUL, shifts and rotates SHALL clear overflow. PASS, LOGIC and MUL SHALL also clear carry.
REQ-026 Undefined op codes (0x10..0x1F) with en=1: out=0, both flags 0, o_dst=i_dst, out_en=1.
REQ-027 Result and flag computation SHALL be purely combinational from the inputs and flag_carry, with no other hidden state.

Reset
REQ-028 While rst_n=0, out, o_dst, flag_carry, flag_overflow and out_en SHALL be 0, asynchronously.
REQ-029 An operation in flight when reset asserts SHALL be discarded. The first result after release SHALL come from the first en=1 edge with rst_n=1.

Structure
REQ-030 Package alu_pkg SHALL hold the data-width constant (16), the shift-width constant (4) and the op-code enum typedef.
REQ-031 One sub-module, alu_shifter, SHALL implement SHL/SHR/SAR/ROL/ROR and return the result plus the shifted-out bit.

Verification
REQ-032 ADD a=0xFFFF b=0x0001 en=1 -> next cycle out=0x0000, carry=1, overflow=0, out_en=1.
REQ-033 ADD a=0x7FFF b=0x0001 -> out=0x8000, carry=0, overflow=1. Then SUB a=0x0000 b=0x0001 -> out=0xFFFF, carry=1, overflow=0.
REQ-034 LOGIC a=0xF0F0 b=0xFF00: truth_table=4'b1000 -> out=0xF000; truth_table=4'b0110 -> out=0x0FF0; flags 0.
REQ-035 SAR a=0x8001 sh_off=1 -> out=0xC000, carry=1. ROL a=0x8001 sh_off=4 -> out=0x0018, carry=0.
REQ-036 ADD 0xFFFF+1 (carry=1), then ADC a=0x0001 b=0x0001 -> out=0x0003, carry=0.
REQ-037 i_dst=0xA with en=1 -> o_dst=0xA, out_en=1. Next cycle en=0 -> out_en=0, out and o_dst hold. Asserting rst_n=0 mid-sequence -> all outputs 0 immediately.
